// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state and
// instruction-class encodings, opcode/funct constants and datapath mux
// select codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST, S_IF, S_ID, S_EXR, S_EXI, S_ADDR, S_MRD, S_MWR,
    S_WBR, S_WBI, S_WBM, S_BR, S_JMP, S_JAL, S_JR
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_JR, C_LW, C_SW, C_BEQ, C_BNE, C_ADDI, C_ORI, C_J, C_JAL, C_ILL
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_PASS  = 3'b100;

endpackage

// File: rtl/mc_main_dec.sv
// Main decoder: opcode/funct -> instruction class. Purely combinational.
module mc_main_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass
);

  // Map the instruction fields onto the class the FSM branches on.
  always_comb begin
    iclass = C_ILL;
    case (opcode)
      OP_RTYPE: iclass = (funct == FN_JR) ? C_JR : C_R;
      OP_LW:    iclass = C_LW;
      OP_SW:    iclass = C_SW;
      OP_BEQ:   iclass = C_BEQ;
      OP_BNE:   iclass = C_BNE;
      OP_ADDI:  iclass = C_ADDI;
      OP_ORI:   iclass = C_ORI;
      OP_J:     iclass = C_J;
      OP_JAL:   iclass = C_JAL;
      default:  iclass = C_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main control FSM. Moore select lines for the datapath
// mux bank plus all write enables. Optional performance counters are
// enabled with the MC_CTRL_PERF_EN macro.
//
// state  | meaning
// -------+------------------------------------------------
// RST    | held after reset, all outputs 0
// IF     | fetch, PC+4, wait for mem_ready
// ID     | decode, branch target -> ALUOut
// EXR    | R-type ALU operation
// EXI    | addi/ori ALU operation
// ADDR   | lw/sw effective address
// MRD    | data memory read, wait for mem_ready
// MWR    | data memory write, wait for mem_ready
// WBR    | R-type writeback to rd
// WBI    | immediate writeback to rt
// WBM    | load writeback to rt
// BR     | beq/bne compare, conditional PC write
// JMP    | j
// JAL    | jal, link to r31
// JR     | jr
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_wr,
  output logic               pc_wr_cond,
  output logic               br_ne,
  output logic               iord,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               ir_wr,
  output logic               reg_wr,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]   cyc_cnt,
  output logic [CNT_W-1:0]   ret_cnt
`endif
);

  state_t  state, state_nxt;
  iclass_t iclass;

  // The branch decision itself is made in the datapath from pc_wr_cond/br_ne.
  logic unused_zero;
  assign unused_zero = zero;

  mc_main_dec u_dec (
    .opcode (opcode),
    .funct  (funct),
    .iclass (iclass)
  );

  // State register; async reset drops every enable at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RST;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RST: state_nxt = S_IF;
      S_IF:  state_nxt = mem_ready ? S_ID : S_IF;
      S_ID: begin
        case (iclass)
          C_R:          state_nxt = S_EXR;
          C_JR:         state_nxt = S_JR;
          C_LW, C_SW:   state_nxt = S_ADDR;
          C_BEQ, C_BNE: state_nxt = S_BR;
          C_ADDI, C_ORI: state_nxt = S_EXI;
          C_J:          state_nxt = S_JMP;
          C_JAL:        state_nxt = S_JAL;
          default:      state_nxt = S_IF;
        endcase
      end
      S_EXR:  state_nxt = S_WBR;
      S_EXI:  state_nxt = S_WBI;
      S_ADDR: state_nxt = (iclass == C_SW) ? S_MWR : S_MRD;
      S_MRD:  state_nxt = mem_ready ? S_WBM : S_MRD;
      S_MWR:  state_nxt = mem_ready ? S_IF : S_MWR;
      S_WBR, S_WBI, S_WBM, S_BR, S_JMP, S_JAL, S_JR: state_nxt = S_IF;
      default: state_nxt = S_RST;
    endcase
  end

  // Output decode per state.
  always_comb begin
    pc_wr      = 1'b0;
    pc_wr_cond = 1'b0;
    br_ne      = 1'b0;
    iord       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = REG_DST_RT;
    mem_to_reg = M2R_ALUOUT;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    pc_src     = PCSRC_ALU;
    alu_op     = ALUOP_W'(ALU_ADD);
    illegal    = 1'b0;
    case (state)
      S_IF: begin
        mem_rd    = 1'b1;
        ir_wr     = mem_ready;
        pc_wr     = mem_ready;
        alu_src_b = SRCB_FOUR;
      end
      S_ID: begin
        alu_src_b = SRCB_IMMSH;
        illegal   = (iclass == C_ILL);
      end
      S_EXR: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_W'(ALU_FUNCT);
      end
      S_EXI: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = (iclass == C_ORI) ? ALUOP_W'(ALU_OR) : ALUOP_W'(ALU_ADD);
      end
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MRD: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
      end
      S_MWR: begin
        mem_wr = 1'b1;
        iord   = 1'b1;
      end
      S_WBR: begin
        reg_wr  = 1'b1;
        reg_dst = REG_DST_RD;
      end
      S_WBI: reg_wr = 1'b1;
      S_WBM: begin
        reg_wr     = 1'b1;
        mem_to_reg = M2R_MDR;
      end
      S_BR: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_W'(ALU_SUB);
        pc_src     = PCSRC_ALUOUT;
        pc_wr_cond = 1'b1;
        br_ne      = (iclass == C_BNE);
      end
      S_JMP: begin
        pc_src = PCSRC_JUMP;
        pc_wr  = 1'b1;
      end
      S_JAL: begin
        pc_src     = PCSRC_JUMP;
        pc_wr      = 1'b1;
        reg_dst    = REG_DST_RA;
        mem_to_reg = M2R_PC;
        reg_wr     = 1'b1;
      end
      S_JR: begin
        pc_src = PCSRC_RS;
        pc_wr  = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MC_CTRL_PERF_EN
  // Cycle and retirement counters; retirement is any return to IF from a
  // real instruction state, illegal decodes included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + CNT_W'(1);
      if (state_nxt == S_IF && state != S_IF && state != S_RST)
        ret_cnt <= ret_cnt + CNT_W'(1);
    end
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule
